// File: rtl/core_start_rx_pkg.sv
`default_nettype none
// =============================================================================
// Module      : core_start_rx_pkg
// Description : Shared constants and helpers for the per-core start receiver.
// Revision    : 1.0 - initial release
// =============================================================================
package core_start_rx_pkg;

   localparam int c_rounds_def = 64;
   localparam int c_num_ctx    = 2;

   typedef logic [c_num_ctx-1:0] ctx_vec_t;

   // Index of the highest set bit needed to hold 'value'; never below 0.
   function automatic int msb_of(input int value);
      return (value < 2) ? 0 : $clog2(value + 1) - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/core_start_rx_ctx_seq.sv
`default_nettype none
// =============================================================================
// Module      : core_start_rx_ctx_seq
// Description : Busy flag, round counter and latched sequence bit of one context.
// Revision    : 1.0 - initial release
// =============================================================================
module core_start_rx_ctx_seq
   import core_start_rx_pkg::*;
#(
   parameter int ROUNDS  = c_rounds_def,
   parameter int RND_MSB = msb_of(ROUNDS - 1)
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             launch,
   input  logic             advance,
   input  logic             seq_in,
   output logic             busy,
   output logic [RND_MSB:0] cnt,
   output logic             seq,
   output logic             last
);

   localparam int               c_last_int = ROUNDS - 1;
   localparam logic [RND_MSB:0] c_last_rnd = c_last_int[RND_MSB:0];

   logic             r_busy;
   logic [RND_MSB:0] r_cnt;
   logic             r_seq;

   // A launch coinciding with the final advance restarts the run.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_seq  <= 1'b0;
      end else if (launch) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_seq  <= seq_in;
      end else if (advance) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == c_last_rnd) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign busy = r_busy;
   assign cnt  = r_cnt;
   assign seq  = r_seq;
   assign last = (r_cnt == c_last_rnd);

endmodule
`default_nettype wire

// File: rtl/core_start_rx.sv
`default_nettype none
// =============================================================================
// Module      : core_start_rx
// Description : Decodes core_start pulses into context runs and issues rounds.
// Revision    : 1.0 - initial release
// =============================================================================
module core_start_rx
   import core_start_rx_pkg::*;
#(
   parameter int ROUNDS  = c_rounds_def,
   parameter int RND_MSB = msb_of(ROUNDS - 1)
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             core_start,
   input  logic             ctx_num,
   input  logic             seq_num,
   input  logic             err_clr,
   output logic             rnd_valid,
   output logic             rnd_ctx,
   output logic [RND_MSB:0] rnd_num,
   output logic             rnd_seq,
   output logic             rnd_last,
   output logic [1:0]       done,
   output logic [1:0]       busy,
   output logic             overrun,
   output logic             phase_err
);

   ctx_vec_t         w_busy;
   ctx_vec_t         w_last;
   ctx_vec_t         w_seq;
   ctx_vec_t         w_sel;
   ctx_vec_t         w_adv;
   ctx_vec_t         w_launch;
   logic [RND_MSB:0] w_cnt [c_num_ctx];
   logic             w_issue;
   logic             w_ovr_set;
   logic             w_phase_set;

   logic             r_rnd_valid;
   logic             r_rnd_ctx;
   logic [RND_MSB:0] r_rnd_num;
   logic             r_rnd_seq;
   logic             r_rnd_last;
   ctx_vec_t         r_done;
   logic             r_overrun;
   logic             r_phase_err;
   logic             r_ctx_prev;
   logic             r_hist_vld;

   generate
      for (genvar g = 0; g < c_num_ctx; g++) begin : g_ctx
         assign w_sel[g]    = (ctx_num == 1'(g));
         assign w_adv[g]    = w_sel[g] & w_busy[g];
         // The slot that issues the final round frees the context for relaunch.
         assign w_launch[g] = core_start & w_sel[g] & (~w_busy[g] | (w_adv[g] & w_last[g]));

         core_start_rx_ctx_seq #(
            .ROUNDS  (ROUNDS),
            .RND_MSB (RND_MSB)
         ) u_ctx_seq (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .launch  (w_launch[g]),
            .advance (w_adv[g]),
            .seq_in  (seq_num),
            .busy    (w_busy[g]),
            .cnt     (w_cnt[g]),
            .seq     (w_seq[g]),
            .last    (w_last[g])
         );
      end
   endgenerate

   assign w_issue     = |w_adv;
   assign w_ovr_set   = core_start & ~(|w_launch);
   assign w_phase_set = r_hist_vld & (ctx_num == r_ctx_prev);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_rnd_valid <= 1'b0;
         r_rnd_ctx   <= 1'b0;
         r_rnd_num   <= '0;
         r_rnd_seq   <= 1'b0;
         r_rnd_last  <= 1'b0;
         r_done      <= '0;
      end else begin
         r_rnd_valid <= w_issue;
         r_done      <= w_adv & w_last;
         if (w_issue) begin
            r_rnd_ctx  <= ctx_num;
            r_rnd_num  <= w_cnt[ctx_num];
            r_rnd_seq  <= w_seq[ctx_num];
            r_rnd_last <= w_last[ctx_num];
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_ctx_prev  <= 1'b0;
         r_hist_vld  <= 1'b0;
         r_overrun   <= 1'b0;
         r_phase_err <= 1'b0;
      end else begin
         r_ctx_prev  <= ctx_num;
         r_hist_vld  <= 1'b1;
         r_overrun   <= w_ovr_set | (r_overrun & ~err_clr);
         r_phase_err <= w_phase_set | (r_phase_err & ~err_clr);
      end
   end

   assign rnd_valid = r_rnd_valid;
   assign rnd_ctx   = r_rnd_ctx;
   assign rnd_num   = r_rnd_num;
   assign rnd_seq   = r_rnd_seq;
   assign rnd_last  = r_rnd_last;
   assign done      = r_done;
   assign busy      = w_busy;
   assign overrun   = r_overrun;
   assign phase_err = r_phase_err;

endmodule
`default_nettype wire

// File: tb/tb_core_start_rx.sv
`default_nettype none
// =============================================================================
// Module      : tb_core_start_rx
// Description : Self-checking bench for core_start_rx against a timing model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_core_start_rx;

   localparam int R = 64;

   logic       CLK        = 1'b0;
   logic       RESET_N    = 1'b0;
   logic       core_start = 1'b0;
   logic       ctx_num    = 1'b0;
   logic       seq_num    = 1'b0;
   logic       err_clr    = 1'b0;
   logic       rnd_valid;
   logic       rnd_ctx;
   logic [5:0] rnd_num;
   logic       rnd_seq;
   logic       rnd_last;
   logic [1:0] done;
   logic [1:0] busy;
   logic       overrun;
   logic       phase_err;

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;
   bit hold    = 1'b0;

   core_start_rx #(.ROUNDS(R), .RND_MSB(5)) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .core_start (core_start),
      .ctx_num    (ctx_num),
      .seq_num    (seq_num),
      .err_clr    (err_clr),
      .rnd_valid  (rnd_valid),
      .rnd_ctx    (rnd_ctx),
      .rnd_num    (rnd_num),
      .rnd_seq    (rnd_seq),
      .rnd_last   (rnd_last),
      .done       (done),
      .busy       (busy),
      .overrun    (overrun),
      .phase_err  (phase_err)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Model: each accepted launch at cycle L occupies its context for cycles
   // L+1..L+2R and issues round k at L+3+2k.
   typedef struct {
      int start;
      bit ctx;
      bit seq;
   } run_t;

   run_t runs[$];
   bit   m_val, m_ctx, m_seq, m_last, m_ovr, m_phe, prev_ctx, hist_vld;
   int   m_num;
   bit [1:0] m_done, m_busy;

   always @(negedge CLK) begin : p_model
      int  d;
      bit  rej;
      if (!RESET_N) begin
         chk("rst_valid", rnd_valid, 0);
         chk("rst_num", rnd_num, 0);
         chk("rst_ctx", rnd_ctx, 0);
         chk("rst_seq", rnd_seq, 0);
         chk("rst_last", rnd_last, 0);
         chk("rst_done", done, 0);
         chk("rst_busy", busy, 0);
         chk("rst_overrun", overrun, 0);
         chk("rst_phase_err", phase_err, 0);
         runs.delete();
         {m_val, m_ctx, m_seq, m_last, m_ovr, m_phe, prev_ctx, hist_vld} = '0;
         m_num  = 0;
         m_done = '0;
         m_busy = '0;
      end else begin
         m_val  = 1'b0;
         m_done = '0;
         m_busy = '0;
         foreach (runs[i]) begin
            d = cyc - runs[i].start;
            if (d >= 1 && d <= 2 * R) m_busy[runs[i].ctx] = 1'b1;
            if (d >= 3 && d <= 2 * R + 1 && ((d - 3) % 2) == 0) begin
               m_val  = 1'b1;
               m_ctx  = runs[i].ctx;
               m_seq  = runs[i].seq;
               m_num  = (d - 3) / 2;
               m_last = (m_num == R - 1);
               if (m_last) m_done[runs[i].ctx] = 1'b1;
            end
         end
         chk("valid", rnd_valid, m_val);
         chk("num", rnd_num, m_num);
         chk("ctx", rnd_ctx, m_ctx);
         chk("seq", rnd_seq, m_seq);
         chk("last", rnd_last, m_last);
         chk("done", done, m_done);
         chk("busy", busy, m_busy);
         chk("overrun", overrun, m_ovr);
         chk("phase_err", phase_err, m_phe);

         rej = 1'b0;
         if (core_start) begin
            foreach (runs[i]) begin
               d = cyc - runs[i].start;
               if (runs[i].ctx == ctx_num && d >= 1 && d < 2 * R) rej = 1'b1;
            end
            if (!rej) runs.push_back('{start: cyc, ctx: ctx_num, seq: seq_num});
         end
         m_ovr = rej | (m_ovr & !err_clr);
         m_phe = (hist_vld && ctx_num == prev_ctx) | (m_phe & !err_clr);
         prev_ctx = ctx_num;
         hist_vld = 1'b1;
         for (int i = runs.size() - 1; i >= 0; i--) begin
            if (cyc - runs[i].start > 2 * R + 1) runs.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
      if (!hold) ctx_num = ~ctx_num;
      core_start = 1'b0;
      err_clr    = 1'b0;
      seq_num    = 1'($urandom_range(0, 1));
   endtask

   task automatic go(input int tgt);
      while (cyc < tgt) step();
   endtask

   task automatic launch(input bit c, input bit s, output int t);
      step();
      while (ctx_num != c) step();
      core_start = 1'b1;
      seq_num    = s;
      t          = cyc;
   endtask

   initial begin : p_stim
      int t;
      int tp;

      go(3);
      @(negedge CLK);
      chk("lit_reset_busy", busy, 0);
      go(4);
      RESET_N = 1'b1;
      go(10);

      // Single launch, seq 1, with seq_num randomised during the run.
      launch(1'b0, 1'b1, t);
      go(t + 1);   @(negedge CLK); chk("lit_busy_t1", busy, 1);
      go(t + 3);   @(negedge CLK); chk("lit_r0_valid", rnd_valid, 1);
                                   chk("lit_r0_num", rnd_num, 0);
                                   chk("lit_r0_seq", rnd_seq, 1);
      go(t + 4);   @(negedge CLK); chk("lit_gap_valid", rnd_valid, 0);
      go(t + 128); @(negedge CLK); chk("lit_busy_t128", busy, 1);
      go(t + 129); @(negedge CLK); chk("lit_done_t129", done, 1);
                                   chk("lit_last_num", rnd_num, 63);
                                   chk("lit_last_flag", rnd_last, 1);
                                   chk("lit_busy_t129", busy, 0);
      go(t + 130); @(negedge CLK); chk("lit_done_t130", done, 0);
      go(t + 135);

      // Overrun, boundary relaunch and error clearing.
      launch(1'b0, 1'b0, t);
      go(t + 50);  core_start = 1'b1;
      go(t + 51);  @(negedge CLK); chk("lit_overrun_set", overrun, 1);
      go(t + 126); core_start = 1'b1;
      go(t + 128); core_start = 1'b1; seq_num = 1'b1;
      go(t + 129); @(negedge CLK); chk("lit_relaunch_done", done, 1);
                                   chk("lit_relaunch_busy", busy, 1);
      go(t + 131); @(negedge CLK); chk("lit_relaunch_r0", rnd_num, 0);
                                   chk("lit_relaunch_seq", rnd_seq, 1);
      go(t + 132); err_clr = 1'b1;
      go(t + 133); @(negedge CLK); chk("lit_overrun_clr", overrun, 0);
      go(t + 134); core_start = 1'b1; err_clr = 1'b1;
      go(t + 135); @(negedge CLK); chk("lit_set_wins", overrun, 1);
      go(t + 136); err_clr = 1'b1;
      go(t + 128 + 135);

      // Both contexts on consecutive cycles.
      launch(1'b0, 1'b1, t);
      step(); core_start = 1'b1; seq_num = 1'b0;
      go(t + 129); @(negedge CLK); chk("lit_dual_done0", done, 1);
      go(t + 130); @(negedge CLK); chk("lit_dual_done1", done, 2);
                                   chk("lit_dual_ctx1", rnd_ctx, 1);
      go(t + 135);

      // Reset in the middle of a run, then a fresh run.
      launch(1'b0, 1'b1, t);
      go(t + 43);  RESET_N = 1'b0;
      @(negedge CLK); chk("lit_midrst_valid", rnd_valid, 0);
      go(t + 46);  RESET_N = 1'b1;
      go(t + 140);
      launch(1'b0, 1'b1, t);
      go(t + 129); @(negedge CLK); chk("lit_fresh_done", done, 1);
      go(t + 135);

      // Phase error: ctx_num held for one extra cycle.
      step();
      hold = 1'b1;
      step();
      hold = 1'b0;
      tp = cyc;
      go(tp + 1);  @(negedge CLK); chk("lit_phase_set", phase_err, 1);
      go(tp + 5);  @(negedge CLK); chk("lit_phase_sticky", phase_err, 1);
      go(tp + 6);  err_clr = 1'b1;
      go(tp + 7);  @(negedge CLK); chk("lit_phase_clr", phase_err, 0);
      go(tp + 10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
